move_validator: RTL and testbench

- Upstream stage of the player-switch logic: accepts a player's cell selection and confirm button, checks legality against the board, commits legal moves.
- Produces the one-cycle valid_move pulse the switch stage consumes to alternate players.
- Owns the 3x3 board register read by display and win-detection logic.

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/input_sync_edge.sv | 43 ++++
 rtl/move_validator.sv | 155 +++++++++++++++
 tb/tb_move_validator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared tic-tac-toe definitions: cell encodings, board size,
//               move limit and the move-validator FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int         NUM_CELLS  = 9;
  localparam logic [3:0] MAX_MOVES  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CHECK        = 3'd1,
    ST_COMMIT       = 3'd2,
    ST_REJECT       = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } mv_state_e;

  // Only X and O may place a mark; 00 and 11 are not players.
  function automatic logic player_legal(input logic [1:0] p);
    return (p == CELL_X) || (p == CELL_O);
  endfunction

endpackage : ttt_pkg
`default_nettype wire

// File: rtl/input_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : input_sync_edge
// Description : Multi-flop synchroniser for an asynchronous level input,
//               followed by a rising-edge detector on the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module input_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_o;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule : input_sync_edge
`default_nettype wire

// File: rtl/move_validator.sv
`default_nettype none
// ============================================================================
// Module      : move_validator
// Description : Accepts a cell selection on a synchronised confirm press,
//               checks legality against the board, commits legal moves and
//               emits one-cycle valid/invalid pulses. Owns the board register.
// Revision    : 1.0 - initial release
// ============================================================================
module move_validator
  import ttt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CELLS   = ttt_pkg::NUM_CELLS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     confirm,
  input  logic [3:0]               cell_sel,
  input  logic [1:0]               current_player,
  input  logic                     game_over,
  input  logic                     clear_board,
  output logic                     valid_move,
  output logic                     invalid_move,
  output logic [2*NUM_CELLS-1:0]   board,
  output logic [3:0]               move_count,
  output logic                     board_full
);

  logic confirm_s;
  logic confirm_rise;

  input_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_confirm_sync (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (confirm),
    .sync_o  (confirm_s),
    .rise_o  (confirm_rise)
  );

  mv_state_e              state_q,   state_d;
  logic [3:0]             cell_q,    cell_d;
  logic [1:0]             player_q,  player_d;
  logic [2*NUM_CELLS-1:0] board_q,   board_d;
  logic [3:0]             count_q,   count_d;
  logic                   valid_q,   valid_d;
  logic                   invalid_q, invalid_d;
  logic                   full_q,    full_d;

  logic [1:0]             target;
  logic                   move_ok;

  // State, captured move, board and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cell_q    <= '0;
      player_q  <= '0;
      board_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      player_q  <= player_d;
      board_q   <= board_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      full_q    <= full_d;
    end
  end

  // Next-state logic: legality check, board update, pulse generation.
  // Pulses and board writes are computed on the CHECK->COMMIT/REJECT
  // transition so they become visible in the COMMIT/REJECT cycle itself.
  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    player_d  = player_q;
    board_d   = board_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    invalid_d = 1'b0;

    target = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_q == 4'(i)) begin
        target = board_q[2*i +: 2];
      end
    end

    move_ok = (cell_q < 4'(NUM_CELLS)) && (target == CELL_EMPTY) &&
              !game_over && player_legal(player_q);

    case (state_q)
      ST_IDLE: begin
        if (confirm_rise) begin
          cell_d   = cell_sel;
          player_d = current_player;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (move_ok) begin
          state_d = ST_COMMIT;
          valid_d = 1'b1;
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_q == 4'(i)) begin
              board_d[2*i +: 2] = player_q;
            end
          end
          count_d = (count_q == MAX_MOVES) ? count_q : count_q + 4'd1;
        end else begin
          state_d   = ST_REJECT;
          invalid_d = 1'b1;
        end
      end
      ST_COMMIT, ST_REJECT: begin
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!confirm_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new-game request overrides any move in flight; the edge detector
    // inside the synchroniser is deliberately left untouched.
    if (clear_board) begin
      state_d   = ST_IDLE;
      board_d   = '0;
      count_d   = '0;
      valid_d   = 1'b0;
      invalid_d = 1'b0;
    end

    full_d = (count_d == MAX_MOVES);
  end

  assign valid_move   = valid_q;
  assign invalid_move = invalid_q;
  assign board        = board_q;
  assign move_count   = count_q;
  assign board_full   = full_q;

endmodule : move_validator
`default_nettype wire

// File: tb/tb_move_validator.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_validator
// Description : Self-checking bench for move_validator: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a behavioural board/timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_validator;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        confirm = 1'b0;
  logic [3:0]  cell_sel = 4'd0;
  logic [1:0]  current_player = 2'b01;
  logic        game_over = 1'b0;
  logic        clear_board = 1'b0;
  logic        valid_move;
  logic        invalid_move;
  logic [17:0] board;
  logic [3:0]  move_count;
  logic        board_full;

  move_validator #(.SYNC_STAGES(SYNC)) dut (
    .clk            (clk),
    .reset          (reset),
    .confirm        (confirm),
    .cell_sel       (cell_sel),
    .current_player (current_player),
    .game_over      (game_over),
    .clear_board    (clear_board),
    .valid_move     (valid_move),
    .invalid_move   (invalid_move),
    .board          (board),
    .move_count     (move_count),
    .board_full     (board_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Board as an array of marks; timing expressed as edge numbers:
  // the synchronised level at edge n is the raw level sampled SYNC-1
  // edges earlier; a press captured at edge c is judged at edge c+1,
  // and the press is finished once the button is seen released at or
  // after edge c+3.
  int         m_board[9];
  int         m_count;
  bit         m_busy;
  int         m_edge;
  int         m_cap;
  logic [3:0] m_cell;
  logic [1:0] m_player;
  bit         exp_valid;
  bit         exp_invalid;
  bit         rawh[$];
  bit         chk_en = 1'b0;

  function automatic bit s_at(input int back);
    return rawh[SYNC-1+back];
  endfunction

  function automatic logic [17:0] model_board();
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(m_board[i]);
    return r;
  endfunction

  task automatic model_init();
    rawh = {};
    for (int i = 0; i < SYNC + 2; i++) rawh.push_back(1'b0);
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_count = 0; m_busy = 0; m_edge = 0; m_cap = 0;
    exp_valid = 0; exp_invalid = 0;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      model_init();
    end else begin
      m_edge++;
      rawh.push_front(confirm);
      void'(rawh.pop_back());
      exp_valid   = 0;
      exp_invalid = 0;
      if (clear_board) begin
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_count = 0;
        m_busy  = 0;
      end else if (m_busy && m_edge == m_cap + 1) begin
        if (m_cell <= 4'd8 && m_board[m_cell] == 0 && !game_over &&
            (m_player == 2'b01 || m_player == 2'b10)) begin
          m_board[m_cell] = int'(m_player);
          if (m_count < 9) m_count++;
          exp_valid = 1;
        end else begin
          exp_invalid = 1;
        end
      end else if (m_busy && m_edge >= m_cap + 3 && !s_at(1)) begin
        m_busy = 0;
      end else if (!m_busy && s_at(1) && !s_at(2)) begin
        m_busy   = 1;
        m_cap    = m_edge;
        m_cell   = cell_sel;
        m_player = current_player;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      cmp("valid_move",   {31'd0, valid_move},   {31'd0, exp_valid});
      cmp("invalid_move", {31'd0, invalid_move}, {31'd0, exp_invalid});
      cmp("board",        {14'd0, board},        {14'd0, model_board()});
      cmp("move_count",   {28'd0, move_count},   m_count);
      cmp("board_full",   {31'd0, board_full},   {31'd0, (m_count == 9)});
    end
  end

  // Pulse counters for literal expectations.
  int n_vp = 0;
  int n_ip = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (valid_move)   n_vp++;
      if (invalid_move) n_ip++;
    end
  end

  task automatic press(input logic [3:0] c, input logic [1:0] p, input int hold);
    @(negedge clk);
    cell_sel = c; current_player = p; confirm = 1'b1;
    repeat (hold) @(negedge clk);
    confirm = 1'b0;
    repeat (SYNC + 8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vb, ib;
    bit seen;

    repeat (3) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    cmp("reset_board",      {14'd0, board}, 32'd0);
    cmp("reset_move_count", {28'd0, move_count}, 32'd0);
    cmp("reset_pulses",     {30'd0, valid_move, invalid_move}, 32'd0);
    cmp("reset_full",       {31'd0, board_full}, 32'd0);

    // First legal move: X on centre.
    vb = n_vp; ib = n_ip;
    press(4'd4, 2'b01, 3);
    cmp("first_valid_count", n_vp - vb, 1);
    cmp("first_board",       {14'd0, board}, 32'h100);
    cmp("first_move_count",  {28'd0, move_count}, 1);

    // Occupied cell, out-of-range cell, game over.
    vb = n_vp; ib = n_ip;
    press(4'd4, 2'b10, 3);
    cmp("occupied_invalid", n_ip - ib, 1);
    cmp("occupied_valid",   n_vp - vb, 0);
    ib = n_ip;
    press(4'd12, 2'b01, 3);
    cmp("range_invalid", n_ip - ib, 1);
    ib = n_ip;
    game_over = 1'b1;
    press(4'd0, 2'b10, 3);
    game_over = 1'b0;
    cmp("gameover_invalid", n_ip - ib, 1);
    cmp("rejects_board",    {14'd0, board}, 32'h100);
    cmp("rejects_count",    {28'd0, move_count}, 1);

    // Long hold yields one move only; re-press on same cell is rejected.
    vb = n_vp; ib = n_ip;
    press(4'd0, 2'b10, 50);
    cmp("hold_one_valid", n_vp - vb, 1);
    cmp("hold_board",     {14'd0, board}, 32'h102);
    press(4'd0, 2'b01, 3);
    cmp("repress_invalid", n_ip - ib, 1);

    // Fill the board from empty.
    @(negedge clk); clear_board = 1'b1;
    @(negedge clk); clear_board = 1'b0;
    for (int i = 0; i < 9; i++) press(4'(i), (i % 2 == 0) ? 2'b01 : 2'b10, 2);
    cmp("full_board", {14'd0, board}, 32'h19999);
    cmp("full_count", {28'd0, move_count}, 9);
    cmp("full_flag",  {31'd0, board_full}, 1);
    ib = n_ip;
    press(4'd0, 2'b10, 2);
    cmp("tenth_invalid", n_ip - ib, 1);
    cmp("tenth_count",   {28'd0, move_count}, 9);

    // Clear during CHECK of a legal press cancels it; held button ignored.
    @(negedge clk); clear_board = 1'b1;
    @(negedge clk); clear_board = 1'b0;
    vb = n_vp; ib = n_ip;
    @(negedge clk);
    cell_sel = 4'd3; current_player = 2'b01; confirm = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk); clear_board = 1'b1;
    @(negedge clk); clear_board = 1'b0;
    repeat (6) @(negedge clk);
    confirm = 1'b0;
    repeat (SYNC + 6) @(negedge clk);
    cmp("clear_no_pulse", (n_vp - vb) + (n_ip - ib), 0);
    cmp("clear_board",    {14'd0, board}, 32'd0);
    cmp("clear_count",    {28'd0, move_count}, 0);

    // Reset asserted during the COMMIT cycle.
    @(negedge clk);
    cell_sel = 4'd5; current_player = 2'b01; confirm = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (valid_move) seen = 1;
    end
    cmp("commit_reached", {31'd0, seen}, 1);
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    cmp("async_reset_board", {14'd0, board}, 32'd0);
    cmp("async_reset_count", {28'd0, move_count}, 0);
    cmp("async_reset_pulse", {30'd0, valid_move, invalid_move}, 0);
    cmp("async_reset_full",  {31'd0, board_full}, 0);
    confirm = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic checked by the model.
    for (int k = 0; k < 4000; k++) begin
      int pr;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) confirm = ~confirm;
      cell_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
      pr = $urandom_range(0, 9);
      current_player = (pr == 0) ? 2'b00 : (pr == 1) ? 2'b11 :
                       (pr < 6) ? 2'b01 : 2'b10;
      game_over   = ($urandom_range(0, 15) == 0);
      clear_board = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    confirm = 1'b0; game_over = 1'b0; clear_board = 1'b0;
    repeat (SYNC + 8) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_move_validator
`default_nettype wire
